neuron_unit: RTL and testbench



---
 rtl/neuron_unit.sv | 55 +++++
 tb/tb_neuron_unit.sv | 116 +++++++++++
 2 files changed

// File: rtl/neuron_unit.sv
// rtl/neuron_unit.sv - integrate-and-fire neuron: masked weight sum with registered threshold fire
//
// Purpose: each cycle, add up the weights of every active input spike line.
//          One cycle later, present that sum and a fire flag (sum >= THRESHOLD).
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous reset, active-high; clears sum and spikes_out
//   spikes_in  - one bit per input line; 1 = line spiked this cycle
//   weights    - packed per-line unsigned weights; weights[i] belongs to line i
//   sum        - registered weighted sum
//   spikes_out - registered fire flag

module neuron_unit #(
  parameter int unsigned NUM_SPIKES = 8,
  parameter int unsigned WBITS      = 3,
  parameter int unsigned THRESHOLD  = 8,
  parameter int unsigned SBITS      = WBITS + $clog2(NUM_SPIKES + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_SPIKES-1:0]            spikes_in,
  input  logic [NUM_SPIKES-1:0][WBITS-1:0] weights,
  output logic [SBITS-1:0]                 sum,
  output logic                             spikes_out
);

  logic [SBITS-1:0] sum_q, sum_d;
  logic             spikes_q, spikes_d;

  // SBITS is sized so the all-lines-at-max-weight total still fits,
  // so the accumulation never wraps.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < int'(NUM_SPIKES); i++) begin
      sum_d = sum_d + {{(SBITS-WBITS){1'b0}}, weights[i] & {WBITS{spikes_in[i]}}};
    end
    // Widen to 32 bits so THRESHOLD values above the sum range simply never fire.
    spikes_d = ({{(32-SBITS){1'b0}}, sum_d} >= THRESHOLD);
  end

  // No membrane state is carried across cycles: every edge reloads from inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q    <= '0;
      spikes_q <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      spikes_q <= spikes_d;
    end
  end

  assign sum        = sum_q;
  assign spikes_out = spikes_q;

endmodule

// File: tb/tb_neuron_unit.sv
// tb/tb_neuron_unit.sv - self-checking bench for neuron_unit against a behavioural model

module tb_neuron_unit;

  typedef logic [7:0][2:0] wrow_t;

  logic        clk;
  logic        rst;
  logic [7:0]  spikes_in;
  wrow_t       weights;
  logic [6:0]  sum;
  logic        spikes_out;

  int errors = 0;
  int checks = 0;

  neuron_unit #(
    .NUM_SPIKES(8),
    .WBITS     (3),
    .THRESHOLD (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .spikes_in (spikes_in),
    .weights   (weights),
    .sum       (sum),
    .spikes_out(spikes_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: total of the weights whose line spiked; fire when total reaches 8.
  function automatic int ref_sum(input logic [7:0] s, input wrow_t w);
    int total = 0;
    for (int i = 0; i < 8; i++)
      if (s[i]) total += int'(w[i]);
    return total;
  endfunction

  function automatic wrow_t all_weights(input int v);
    wrow_t w;
    for (int i = 0; i < 8; i++) w[i] = 3'(v);
    return w;
  endfunction

  // Drive inputs away from the edge, clock once, then sample 1 time unit after the edge.
  task automatic step(input string tag, input logic r, input logic [7:0] s, input wrow_t w);
    int exp_sum;
    int exp_fire;
    @(negedge clk);
    rst       = r;
    spikes_in = s;
    weights   = w;
    exp_sum   = r ? 0 : ref_sum(s, w);
    exp_fire  = (!r && exp_sum >= 8) ? 1 : 0;
    @(posedge clk);
    #1;
    check({tag, ".sum"},  int'(sum),        exp_sum);
    check({tag, ".fire"}, int'(spikes_out), exp_fire);
  endtask

  initial begin
    wrow_t w;
    rst       = 1'b1;
    spikes_in = '0;
    weights   = '0;

    step("reset0", 1'b1, 8'hFF, all_weights(7));
    step("reset1", 1'b1, 8'hFF, all_weights(7));

    step("nospikes", 1'b0, 8'h00, all_weights(7));

    w = all_weights(7);
    w[0] = 3'd5;
    step("single", 1'b0, 8'b0000_0001, w);

    w = all_weights(7);
    w[0] = 3'd4;
    w[1] = 3'd4;
    step("exact_thr", 1'b0, 8'b0000_0011, w);

    w = all_weights(7);
    w[0] = 3'd3;
    w[1] = 3'd4;
    step("below_thr", 1'b0, 8'b0000_0011, w);

    step("max", 1'b0, 8'hFF, all_weights(7));
    step("nomemory", 1'b0, 8'h00, all_weights(7));

    for (int k = 0; k < 25; k++) begin
      logic [7:0] s;
      s = 8'($urandom);
      for (int i = 0; i < 8; i++) w[i] = 3'($urandom_range(0, 7));
      step($sformatf("rand%0d", k), (k == 12) ? 1'b1 : 1'b0, s, w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
